tpu_tile_sched: RTL and testbench

- Tile scheduler for the systolic-array TPU.
- Latches an (m, n, k) GEMM request: A is m×k, B is k×n.
- Splits the output into ARRAY_SIZE×ARRAY_SIZE tiles and sequences global-buffer reads, PE accumulator clear/feed, drain, and output-buffer writes for each tile.
- Sits inside top between the in_valid/out_valid handshake and the PE array / gbuff address ports.

---
 rtl/tpu_tile_sched.sv | 191 +++++++++++++++++++
 tb/tb_tpu_tile_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sched
// Function : GEMM tile scheduler; sequences gbuff reads, PE clear/feed/drain
//            and output-buffer writes for each ARRAY_SIZE x ARRAY_SIZE tile.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_tile_sched #(
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_W     = 10,
  parameter int RW         = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        m,
  input  logic [4:0]        n,
  input  logic [4:0]        k,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  output logic              pe_clear,
  output logic              pe_feed_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [RW-1:0]     out_row_sel,
  output logic              busy,
  output logic              out_valid
);

  localparam int CW = $clog2(2 * ARRAY_SIZE);
  localparam logic [CW-1:0]     c_flush_last = CW'(2 * ARRAY_SIZE - 1);
  localparam logic [RW-1:0]     c_row_last   = RW'(ARRAY_SIZE - 1);
  localparam logic [CW-1:0]     c_cnt_one    = CW'(1);
  localparam logic [RW-1:0]     c_row_one    = RW'(1);
  localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  logic [4:0]        r_k;
  logic [4:0]        r_kk;
  logic [4:0]        r_tm;
  logic [4:0]        r_tn;
  logic [4:0]        r_tm_last;
  logic [4:0]        r_tn_last;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [ADDR_W-1:0] r_out_ptr;

  logic [5:0]        w_tiles_m;
  logic [5:0]        w_tiles_n;
  logic [ADDR_W-1:0] w_k_ext;
  logic              w_zero_dim;

  // Tile counts only matter when every dimension is non-zero.
  assign w_tiles_m  = 6'((32'(m) + ARRAY_SIZE - 1) / ARRAY_SIZE);
  assign w_tiles_n  = 6'((32'(n) + ARRAY_SIZE - 1) / ARRAY_SIZE);
  assign w_k_ext    = ADDR_W'(r_k);
  assign w_zero_dim = (m == 5'd0) || (n == 5'd0) || (k == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_kk          <= '0;
      r_tm          <= '0;
      r_tn          <= '0;
      r_tm_last     <= '0;
      r_tn_last     <= '0;
      r_cnt         <= '0;
      r_a_base      <= '0;
      r_b_base      <= '0;
      r_out_ptr     <= '0;
      a_rd_en       <= 1'b0;
      a_addr        <= '0;
      b_rd_en       <= 1'b0;
      b_addr        <= '0;
      pe_clear      <= 1'b0;
      pe_feed_valid <= 1'b0;
      out_wr_en     <= 1'b0;
      out_addr      <= '0;
      out_row_sel   <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      pe_clear      <= 1'b0;
      out_valid     <= 1'b0;
      pe_feed_valid <= a_rd_en;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            busy      <= 1'b1;
            r_k       <= k;
            r_tm_last <= 5'(w_tiles_m - 6'd1);
            r_tn_last <= 5'(w_tiles_n - 6'd1);
            r_tm      <= '0;
            r_tn      <= '0;
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_out_ptr <= '0;
            if (w_zero_dim) begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              r_state  <= S_CLEAR;
              pe_clear <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_FEED;
          a_rd_en <= 1'b1;
          b_rd_en <= 1'b1;
          a_addr  <= r_a_base;
          b_addr  <= r_b_base;
          r_kk    <= '0;
        end
        S_FEED: begin
          if (r_kk == r_k - 5'd1) begin
            a_rd_en <= 1'b0;
            b_rd_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_kk   <= r_kk + 5'd1;
            a_addr <= a_addr + c_addr_one;
            b_addr <= b_addr + c_addr_one;
          end
        end
        S_FLUSH: begin
          if (r_cnt == c_flush_last) begin
            r_state     <= S_WRITE;
            out_wr_en   <= 1'b1;
            out_row_sel <= '0;
            out_addr    <= r_out_ptr;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_WRITE: begin
          if (out_row_sel == c_row_last) begin
            out_wr_en <= 1'b0;
            r_out_ptr <= out_addr + c_addr_one;
            // tn is the inner loop; b_base rewinds whenever tn wraps.
            if (r_tn == r_tn_last) begin
              r_tn     <= '0;
              r_b_base <= '0;
              if (r_tm == r_tm_last) begin
                r_state   <= S_DONE;
                out_valid <= 1'b1;
              end else begin
                r_tm     <= r_tm + 5'd1;
                r_a_base <= r_a_base + w_k_ext;
                r_state  <= S_CLEAR;
                pe_clear <= 1'b1;
              end
            end else begin
              r_tn     <= r_tn + 5'd1;
              r_b_base <= r_b_base + w_k_ext;
              r_state  <= S_CLEAR;
              pe_clear <= 1'b1;
            end
          end else begin
            out_row_sel <= out_row_sel + c_row_one;
            out_addr    <= out_addr + c_addr_one;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_tile_sched
// Function : Directed self-checking bench for tpu_tile_sched (ARRAY_SIZE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] m, n, k;
  logic       a_rd_en, b_rd_en, pe_clear, pe_feed_valid, out_wr_en, busy, out_valid;
  logic [9:0] a_addr, b_addr, out_addr;
  logic [1:0] out_row_sel;

  int checks = 0;
  int errors = 0;
  int a_q[$], b_q[$], o_q[$], r_q[$];
  int feed_c[$], pfv_c[$], clr_c[$], wr_c[$];
  int busy_n, ov_n;

  tpu_tile_sched #(.ARRAY_SIZE(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .m(m), .n(n), .k(k),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .b_rd_en(b_rd_en), .b_addr(b_addr),
    .pe_clear(pe_clear), .pe_feed_valid(pe_feed_valid), .out_wr_en(out_wr_en),
    .out_addr(out_addr), .out_row_sel(out_row_sel), .busy(busy), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a_rd_en"}, int'(a_rd_en), 0);
    chk({tag, " a_addr"}, int'(a_addr), 0);
    chk({tag, " b_rd_en"}, int'(b_rd_en), 0);
    chk({tag, " b_addr"}, int'(b_addr), 0);
    chk({tag, " pe_clear"}, int'(pe_clear), 0);
    chk({tag, " pe_feed_valid"}, int'(pe_feed_valid), 0);
    chk({tag, " out_wr_en"}, int'(out_wr_en), 0);
    chk({tag, " out_addr"}, int'(out_addr), 0);
    chk({tag, " out_row_sel"}, int'(out_row_sel), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
  endtask

  // Called at a negedge while IDLE; cycle 0 is the cycle carrying in_valid.
  task automatic run_req(input logic [4:0] mm, input logic [4:0] nn, input logic [4:0] kk,
                         input int pulse_at, input int max_cyc, output int done_cyc);
    a_q.delete(); b_q.delete(); o_q.delete(); r_q.delete();
    feed_c.delete(); pfv_c.delete(); clr_c.delete(); wr_c.delete();
    busy_n = 0; ov_n = 0; done_cyc = -1;
    m = mm; n = nn; k = kk; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; m = 5'd31; n = 5'd31; k = 5'd31;
    for (int c = 1; c <= max_cyc; c++) begin
      if (a_rd_en) begin a_q.push_back(int'(a_addr)); feed_c.push_back(c); end
      if (b_rd_en) b_q.push_back(int'(b_addr));
      if (pe_clear) clr_c.push_back(c);
      if (pe_feed_valid) pfv_c.push_back(c);
      if (out_wr_en) begin
        o_q.push_back(int'(out_addr)); r_q.push_back(int'(out_row_sel)); wr_c.push_back(c);
      end
      if (busy) busy_n++;
      if (out_valid) begin ov_n++; done_cyc = c; end
      if (done_cyc >= 0) break;
      if (c == pulse_at) begin
        in_valid = 1'b1; m = 5'd4; n = 5'd4; k = 5'd4;
      end else begin
        in_valid = 1'b0; m = 5'd31; n = 5'd31; k = 5'd31;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Expected schedule: tile t starts at 1 + t*(1 + k + 12); tm outer, tn inner.
  task automatic check_req(input string tag, input int mm, input int nn, input int kk,
                           input int done_cyc);
    int tmc, tnc, per, tiles, base, e, w;
    tmc   = (mm + 3) / 4;
    tnc   = (nn + 3) / 4;
    per   = 1 + kk + 12;
    tiles = (mm == 0 || nn == 0 || kk == 0) ? 0 : tmc * tnc;
    chk({tag, " done_cycle"}, done_cyc, 1 + tiles * per);
    chk({tag, " out_valid_pulses"}, ov_n, 1);
    chk({tag, " busy_cycles"}, busy_n, 1 + tiles * per);
    chk({tag, " n_clear"}, clr_c.size(), tiles);
    chk({tag, " n_a_rd"}, a_q.size(), tiles * kk);
    chk({tag, " n_b_rd"}, b_q.size(), tiles * kk);
    chk({tag, " n_feed_valid"}, pfv_c.size(), tiles * kk);
    chk({tag, " n_wr"}, o_q.size(), tiles * 4);
    if (clr_c.size() == tiles && a_q.size() == tiles * kk && b_q.size() == tiles * kk &&
        pfv_c.size() == tiles * kk && o_q.size() == tiles * 4) begin
      for (int t = 0; t < tiles; t++) begin
        base = 1 + t * per;
        chk($sformatf("%s clear_cyc[%0d]", tag, t), clr_c[t], base);
        for (int j = 0; j < kk; j++) begin
          e = t * kk + j;
          chk($sformatf("%s a_addr[%0d]", tag, e), a_q[e], (t / tnc) * kk + j);
          chk($sformatf("%s b_addr[%0d]", tag, e), b_q[e], (t % tnc) * kk + j);
          chk($sformatf("%s feed_cyc[%0d]", tag, e), feed_c[e], base + 1 + j);
          chk($sformatf("%s pfv_cyc[%0d]", tag, e), pfv_c[e], base + 2 + j);
        end
        for (int r = 0; r < 4; r++) begin
          w = t * 4 + r;
          chk($sformatf("%s out_addr[%0d]", tag, w), o_q[w], w);
          chk($sformatf("%s row_sel[%0d]", tag, w), r_q[w], r);
          chk($sformatf("%s wr_cyc[%0d]", tag, w), wr_c[w], base + 1 + kk + 8 + r);
        end
      end
    end
    @(negedge clk);
    chk({tag, " idle busy"}, int'(busy), 0);
    chk({tag, " idle out_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    int dc;
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; m = '0; n = '0; k = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    run_req(5'd4, 5'd4, 5'd4, -1, 200, dc);
    check_req("s1_444", 4, 4, 4, dc);

    run_req(5'd8, 5'd8, 5'd3, -1, 200, dc);
    check_req("s2_883", 8, 8, 3, dc);

    run_req(5'd5, 5'd1, 5'd2, -1, 200, dc);
    check_req("s3_512", 5, 1, 2, dc);

    run_req(5'd4, 5'd4, 5'd0, -1, 50, dc);
    check_req("s4_k0", 4, 4, 0, dc);

    run_req(5'd0, 5'd7, 5'd3, -1, 50, dc);
    check_req("s4_m0", 0, 7, 3, dc);

    // Second in_valid lands in FEED (cycle 3) and must be ignored.
    run_req(5'd8, 5'd8, 5'd3, 3, 200, dc);
    check_req("s5_ignore", 8, 8, 3, dc);
    run_req(5'd5, 5'd1, 5'd2, -1, 200, dc);
    check_req("s5_fresh", 5, 1, 2, dc);

    // Reset in cycle 15, inside WRITE of the first of four tiles.
    m = 5'd8; n = 5'd8; k = 5'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("s6 in_write", int'(out_wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("s6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid || busy || out_wr_en || a_rd_en) bad++;
    end
    chk("s6 quiet_after_reset", bad, 0);

    run_req(5'd4, 5'd4, 5'd4, -1, 200, dc);
    check_req("s6_rerun", 4, 4, 4, dc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
